ddr_arbiter: RTL and testbench

Burst-aware two-master arbiter for the shared DDR3 host port. It time-shares the port between the core datapath (master A, e.g. F2 sprite/save-state streams) and the ROM loading path (master B). Grants are never switched mid-burst and never while read beats are still in flight. It replaces a plain combinational mux so that both masters may run concurrently after ROM load, for example save-state streaming alongside background ROM copies.

---
 rtl/ddr_arbiter.sv | 157 +++++++++++++++
 tb/tb_ddr_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arbiter.sv
// Burst-aware two-master arbiter for the shared DDR3 host port.
// Ports: clk, reset_n (sync, active low); per-master a_*/b_* command
//   groups (acquire, addr, wdata, byteenable, burstcnt, read, write)
//   with busy/rdata/rdata_ready returns; host_* muxed command outputs,
//   host_busy/host_rdata/host_rdata_ready inputs; grant (01=A, 10=B).
// Build option DDR_ARB_ROUND_ROBIN_EN: alternate on contested requests
//   instead of fixed A-first priority.
module ddr_arbiter #(
  parameter int CNT_W = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_acquire,
  input  logic [31:0] a_addr,
  input  logic [63:0] a_wdata,
  input  logic [7:0]  a_byteenable,
  input  logic [7:0]  a_burstcnt,
  input  logic        a_read,
  input  logic        a_write,
  output logic        a_busy,
  output logic [63:0] a_rdata,
  output logic        a_rdata_ready,
  input  logic        b_acquire,
  input  logic [31:0] b_addr,
  input  logic [63:0] b_wdata,
  input  logic [7:0]  b_byteenable,
  input  logic [7:0]  b_burstcnt,
  input  logic        b_read,
  input  logic        b_write,
  output logic        b_busy,
  output logic [63:0] b_rdata,
  output logic        b_rdata_ready,
  output logic [31:0] host_addr,
  output logic [63:0] host_wdata,
  output logic [7:0]  host_byteenable,
  output logic [7:0]  host_burstcnt,
  output logic        host_read,
  output logic        host_write,
  input  logic        host_busy,
  input  logic [63:0] host_rdata,
  input  logic        host_rdata_ready,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nx;
  logic [7:0]       wbeats;
  logic             wip;
  logic             req_a;
  logic             req_b;
  logic             own_a;
  logic             own_b;
  logic             rd_acc;
  logic             wr_acc;
  logic             beat_ok;
  logic             pick_a;
  logic             idle_x;

  assign req_a = a_acquire | a_read | a_write;
  assign req_b = b_acquire | b_read | b_write;
  assign own_a = (state == OWN_A);
  assign own_b = (state == OWN_B);
  assign grant = {own_b, own_a};

  assign host_addr       = own_b ? b_addr : a_addr;
  assign host_wdata      = own_b ? b_wdata : a_wdata;
  assign host_byteenable = own_b ? b_byteenable : a_byteenable;
  assign host_burstcnt   = own_b ? b_burstcnt : a_burstcnt;
  assign host_read  = (own_a & a_read) | (own_b & b_read);
  assign host_write = (own_a & a_write) | (own_b & b_write);

  assign a_busy  = own_a ? host_busy : 1'b1;
  assign b_busy  = own_b ? host_busy : 1'b1;
  assign a_rdata = host_rdata;
  assign b_rdata = host_rdata;

  assign rd_acc = host_read & ~host_busy;
  assign wr_acc = host_write & ~host_busy;

  // A beat is legal if reads are pending, or a read is being
  // accepted in the same cycle; stray beats are swallowed here.
  assign beat_ok = host_rdata_ready &
                   ((outstanding != '0) | rd_acc);

  assign a_rdata_ready = own_a & beat_ok;
  assign b_rdata_ready = own_b & beat_ok;

  assign wip    = (wbeats != 8'd0);
  assign idle_x = (outstanding == '0) & ~wip;

  always_comb begin
    outstanding_nx = outstanding;
    if (rd_acc)
      outstanding_nx = outstanding_nx + CNT_W'(host_burstcnt);
    if (beat_ok)
      outstanding_nx = outstanding_nx - 1'b1;
  end

`ifdef DDR_ARB_ROUND_ROBIN_EN
  logic last_b;

  assign pick_a = req_a & (~req_b | last_b);

  always_ff @(posedge clk) begin
    if (!reset_n)
      last_b <= 1'b1;
    else if (state != IDLE)
      last_b <= own_b;
  end
`else
  assign pick_a = req_a;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (pick_a)
          state_nx = OWN_A;
        else if (req_b)
          state_nx = OWN_B;
      end
      OWN_A: begin
        if (!req_a && idle_x)
          state_nx = req_b ? OWN_B : IDLE;
      end
      OWN_B: begin
        if (!req_b && idle_x)
          state_nx = req_a ? OWN_A : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      outstanding <= '0;
      wbeats      <= 8'd0;
    end else begin
      state       <= state_nx;
      outstanding <= outstanding_nx;
      // First beat of a burst loads the remaining count.
      if (wr_acc)
        wbeats <= wip ? wbeats - 8'd1 : host_burstcnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed self-checking bench for ddr_arbiter.
// Linear stimulus; immediate assertions at each check point.
module tb_ddr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_acquire, b_acquire;
  logic [31:0] a_addr, b_addr;
  logic [63:0] a_wdata, b_wdata;
  logic [7:0]  a_byteenable, b_byteenable;
  logic [7:0]  a_burstcnt, b_burstcnt;
  logic        a_read, b_read, a_write, b_write;
  logic        a_busy, b_busy;
  logic [63:0] a_rdata, b_rdata;
  logic        a_rdata_ready, b_rdata_ready;
  logic [31:0] host_addr;
  logic [63:0] host_wdata;
  logic [7:0]  host_byteenable, host_burstcnt;
  logic        host_read, host_write;
  logic        host_busy;
  logic [63:0] host_rdata;
  logic        host_rdata_ready;
  logic [1:0]  grant;

  int total = 0;
  int bad   = 0;
  int acc;
  logic [1:0] exp_g [4];

  always #5 clk = ~clk;

  ddr_arbiter #(.CNT_W(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_acquire(a_acquire), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_byteenable(a_byteenable), .a_burstcnt(a_burstcnt),
    .a_read(a_read), .a_write(a_write), .a_busy(a_busy),
    .a_rdata(a_rdata), .a_rdata_ready(a_rdata_ready),
    .b_acquire(b_acquire), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_byteenable(b_byteenable), .b_burstcnt(b_burstcnt),
    .b_read(b_read), .b_write(b_write), .b_busy(b_busy),
    .b_rdata(b_rdata), .b_rdata_ready(b_rdata_ready),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_byteenable(host_byteenable), .host_burstcnt(host_burstcnt),
    .host_read(host_read), .host_write(host_write),
    .host_busy(host_busy), .host_rdata(host_rdata),
    .host_rdata_ready(host_rdata_ready), .grant(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
`ifdef DDR_ARB_ROUND_ROBIN_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10;
    exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01;
    exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    reset_n = 1'b0;
    a_acquire = 0; b_acquire = 0;
    a_addr = 32'hA000_0100; b_addr = 32'hB000_0200;
    a_wdata = 64'hAAAA; b_wdata = 64'h0;
    a_byteenable = 8'h0F; b_byteenable = 8'hF0;
    a_burstcnt = 8'd4; b_burstcnt = 8'd8;
    a_read = 1; b_read = 0; a_write = 0; b_write = 0;
    host_busy = 0; host_rdata = 64'h0; host_rdata_ready = 1;

    // reset held 3 cycles with a_read asserted
    repeat (3) tick();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_host_read", 64'(host_read), 64'd0);
    chk("rst_a_busy", 64'(a_busy), 64'd1);
    chk("rst_b_busy", 64'(b_busy), 64'd1);
    chk("rst_a_rdy", 64'(a_rdata_ready), 64'd0);
    chk("rst_outst", 64'(dut.outstanding), 64'd0);
    host_rdata_ready = 0;
    reset_n = 1;
    b_write = 1;
    tick();
    // A granted, read of 4 presented; B waiting with a write
    chk("rel_grant", 64'(grant), 64'd1);
    chk("a_host_read", 64'(host_read), 64'd1);
    chk("a_host_write", 64'(host_write), 64'd0);
    chk("a_host_addr", 64'(host_addr), 64'hA000_0100);
    chk("a_host_bc", 64'(host_burstcnt), 64'd4);
    chk("a_busy_own", 64'(a_busy), 64'd0);
    chk("b_busy_wait", 64'(b_busy), 64'd1);
    tick();
    a_read = 0;
    chk("rd_outst4", 64'(dut.outstanding), 64'd4);
    for (int i = 0; i < 4; i++) begin
      host_rdata_ready = 1;
      host_rdata = 64'hD0 + 64'(i);
      #1;
      chk("a_rdy_beat", 64'(a_rdata_ready), 64'd1);
      chk("a_rdata", a_rdata, 64'hD0 + 64'(i));
      chk("b_rdy_beat", 64'(b_rdata_ready), 64'd0);
      tick();
      host_rdata_ready = 0;
      chk("rd_hold_grant", 64'(grant), 64'd1);
    end
    tick();
    chk("handover_b", 64'(grant), 64'd2);

    // B write burst of 8 with stalls, a gap, and A requesting mid-way
    acc = 0;
    for (int c = 0; c < 11; c++) begin
      b_write = (c != 4);
      host_busy = (c == 2 || c == 6);
      b_wdata = 64'hB000 + 64'(acc);
      if (c == 3) begin
        a_read = 1;
        a_burstcnt = 8'd2;
        a_addr = 32'hA000_0300;
      end
      #1;
      chk("wr_grant", 64'(grant), 64'd2);
      chk("wr_a_busy", 64'(a_busy), 64'd1);
      chk("wr_b_busy", 64'(b_busy), 64'(host_busy));
      chk("wr_hwrite", 64'(host_write), 64'(c != 4));
      if (c != 4) begin
        chk("wr_wdata", host_wdata, 64'hB000 + 64'(acc));
        chk("wr_be", 64'(host_byteenable), 64'hF0);
      end
      if (b_write && !host_busy)
        acc++;
      tick();
    end
    b_write = 0;
    host_busy = 0;
    #1;
    chk("wr_end_grant", 64'(grant), 64'd2);
    chk("wr_end_a_busy", 64'(a_busy), 64'd1);
    tick();
    chk("wr_to_a", 64'(grant), 64'd1);
    chk("wr_to_a_busy", 64'(a_busy), 64'd0);
    chk("a2_host_read", 64'(host_read), 64'd1);
    chk("a2_host_bc", 64'(host_burstcnt), 64'd2);
    chk("a2_host_addr", 64'(host_addr), 64'hA000_0300);

    // read accept of 2 with a beat in the same cycle
    host_rdata_ready = 1;
    host_rdata = 64'hE1;
    #1;
    chk("same_cyc_rdy", 64'(a_rdata_ready), 64'd1);
    tick();
    a_read = 0;
    host_rdata_ready = 0;
    chk("same_cyc_outst", 64'(dut.outstanding), 64'd1);
    chk("same_cyc_grant", 64'(grant), 64'd1);
    host_rdata_ready = 1;
    tick();
    host_rdata_ready = 0;
    chk("last_beat_outst", 64'(dut.outstanding), 64'd0);
    chk("last_beat_hold", 64'(grant), 64'd1);
    tick();
    chk("release_idle", 64'(grant), 64'd0);

    // stray beats are dropped in IDLE and with nothing pending
    host_rdata_ready = 1;
    #1;
    chk("stray_idle_a", 64'(a_rdata_ready), 64'd0);
    chk("stray_idle_b", 64'(b_rdata_ready), 64'd0);
    host_rdata_ready = 0;
    a_acquire = 1;
    tick();
    chk("acq_grant", 64'(grant), 64'd1);
    host_rdata_ready = 1;
    #1;
    chk("stray_own_a", 64'(a_rdata_ready), 64'd0);
    tick();
    host_rdata_ready = 0;
    chk("stray_outst", 64'(dut.outstanding), 64'd0);

    // acquire lock holds off B for 100 cycles
    b_read = 1;
    b_burstcnt = 8'd1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("lock_grant", 64'(grant), 64'd1);
    end
    chk("lock_b_busy", 64'(b_busy), 64'd1);
    a_acquire = 0;
    tick();
    chk("unlock_b", 64'(grant), 64'd2);
    chk("unlock_b_busy", 64'(b_busy), 64'd0);
    chk("unlock_hread", 64'(host_read), 64'd1);
    chk("unlock_haddr", 64'(host_addr), 64'hB000_0200);
    b_read = 0;
    #1;
    chk("b_drop_hread", 64'(host_read), 64'd0);
    tick();
    chk("b_release", 64'(grant), 64'd0);

    // simultaneous requests from IDLE, host stalled throughout
    host_busy = 1;
    for (int i = 0; i < 4; i++) begin
      a_read = 1;
      b_read = 1;
      tick();
      chk("contest_grant", 64'(grant), 64'(exp_g[i]));
      chk("contest_hread", 64'(host_read), 64'd1);
      a_read = 0;
      b_read = 0;
      tick();
      chk("contest_idle", 64'(grant), 64'd0);
    end
    host_busy = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
